// File: rtl/instr_loader.sv
// Boot-time program loader. It takes a length-prefixed, big-endian byte stream
// and writes the words to consecutive instruction-memory addresses starting
// at 0. The CPU is held stalled for the whole session.
module instr_loader #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_en_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DAT_HI = 3'd3;
  localparam logic [2:0] S_DAT_LO = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  logic [2:0]    state;
  logic [15:0]   len;
  logic [7:0]    hi;
  logic          accept;
  logic [15:0]   len_rx;
  logic [ADDR_W:0] wc_inc;

  // Every output is a decode of the registered state, so nothing on the byte
  // inputs can reach the memory write strobe combinationally.
  assign byte_ready   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                        (state == S_DAT_HI) || (state == S_DAT_LO);
  assign mem_en_write = (state == S_WRITE);
  assign done         = (state == S_DONE);
  assign cpu_hold     = (state != S_IDLE);

  assign accept = byte_valid && byte_ready;
  // Full length as it will look once the low byte is latched.
  assign len_rx = {len[15:8], byte_data};
  // Counting is done on the wider word_count so len == MAX_WORDS terminates
  // without relying on the address register.
  assign wc_inc = word_count + 1'b1;

  // Loader FSM plus the datapath registers it steers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len        <= '0;
      hi         <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      word_count <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_LEN_HI;
            err        <= 1'b0;
            word_count <= '0;
            mem_addr   <= '0;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len[15:8] <= byte_data;
            state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len[7:0] <= byte_data;
            if (len_rx == 16'd0 || len_rx > 16'(MAX_WORDS)) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              state <= S_DAT_HI;
            end
          end
        end
        S_DAT_HI: begin
          if (accept) begin
            hi    <= byte_data;
            state <= S_DAT_LO;
          end
        end
        S_DAT_LO: begin
          if (accept) begin
            mem_data <= DATA_W'({hi, byte_data});
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          word_count <= wc_inc;
          // Saturate rather than wrap after the top address is written.
          if (mem_addr != '1) mem_addr <= mem_addr + 1'b1;
          if (16'(wc_inc) == len) state <= S_DONE;
          else                    state <= S_DAT_HI;
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed frames, an expected-write queue as the
// reference model, and a per-cycle compare process on the memory write port.
module tb_instr_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_en_write, cpu_hold, done, err;
  logic [10:0] mem_addr;
  logic [15:0] mem_data;
  logic [11:0] word_count;

  instr_loader #(.ADDR_W(11), .DATA_W(16), .MAX_WORDS(2048)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_en_write(mem_en_write),
    .mem_addr(mem_addr), .mem_data(mem_data), .cpu_hold(cpu_hold),
    .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] addr;
    logic [15:0] data;
  } wr_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  wr_t         exp_q[$];
  logic [15:0] tb_mem [0:2047];
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  logic        prev_en  = 1'b0;
  logic [10:0] last_addr = '0;
  logic [15:0] last_data = '0;
  bit          gaps = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every write must be the next one the model expects.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (mem_en_write) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e.addr));
          chk("wr_data", 32'(mem_data), 32'(e.data));
        end
        chk("en_single_cycle", 32'(prev_en), 32'd0);
        chk("ready_low_in_write", 32'(byte_ready), 32'd0);
        tb_mem[mem_addr] = mem_data;
        last_addr = mem_addr;
        last_data = mem_data;
        wr_cnt++;
      end
      if (done) done_cnt++;
      prev_en = mem_en_write;
    end else begin
      prev_en = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      chk("byte_ready_timeout", 32'd0, 32'd1);
      byte_valid = 1'b0;
    end else begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_seen", 32'(done_cnt), 32'(target));
  endtask

  task automatic push_wr(input logic [10:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_frame3();
    push_wr(11'd0, 16'h1234);
    push_wr(11'd1, 16'hABCD);
    push_wr(11'd2, 16'h0007);
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h00); send_byte(8'h07);
  endtask

  initial begin
    int w0, d0;
    logic [15:0] w;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(byte_ready), 0);
    chk("rst_en", 32'(mem_en_write), 0);
    chk("rst_hold", 32'(cpu_hold), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_data", 32'(mem_data), 0);
    chk("rst_wc", 32'(word_count), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: three-word frame with exact latency
    do_start();
    chk("t1_hold_loading", 32'(cpu_hold), 1);
    send_frame3();
    chk("t1_write_lat", 32'(mem_en_write), 1);
    @(negedge clk);
    chk("t1_done_lat", 32'(done), 1);
    chk("t1_wc", 32'(word_count), 3);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_hold_after", 32'(cpu_hold), 0);
    #1;
    chk("t1_writes", 32'(wr_cnt), 3);
    chk("t1_done_cnt", 32'(done_cnt), 1);
    chk("t1_mem0", 32'(tb_mem[0]), 32'h1234);
    chk("t1_mem1", 32'(tb_mem[1]), 32'hABCD);
    chk("t1_mem2", 32'(tb_mem[2]), 32'h0007);

    // 2: zero length
    w0 = wr_cnt; d0 = done_cnt;
    do_start();
    send_byte(8'h00); send_byte(8'h00);
    chk("t2_err", 32'(err), 1);
    chk("t2_hold_in_err", 32'(cpu_hold), 1);
    @(negedge clk);
    chk("t2_hold_drop", 32'(cpu_hold), 0);
    repeat (3) @(negedge clk);
    chk("t2_err_sticky", 32'(err), 1);
    #1;
    chk("t2_no_writes", 32'(wr_cnt), 32'(w0));
    chk("t2_no_done", 32'(done_cnt), 32'(d0));

    // 3: oversize length, then a good one-word frame
    do_start();
    send_byte(8'h08); send_byte(8'h01);
    chk("t3_err", 32'(err), 1);
    @(negedge clk);
    chk("t3_hold_drop", 32'(cpu_hold), 0);
    #1;
    chk("t3_no_writes", 32'(wr_cnt), 32'(w0));
    d0 = done_cnt;
    do_start();
    chk("t3_err_cleared", 32'(err), 0);
    push_wr(11'd0, 16'hBEEF);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hBE); send_byte(8'hEF);
    wait_done(d0 + 1);
    chk("t3_err_after", 32'(err), 0);
    chk("t3_mem0", 32'(tb_mem[0]), 32'hBEEF);
    chk("t3_wc", 32'(word_count), 1);

    // 4: random valid gaps, same image as test 1
    for (int i = 0; i < 3; i++) tb_mem[i] = 16'h0;
    gaps = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    do_start();
    send_frame3();
    gaps = 1'b0;
    wait_done(d0 + 1);
    chk("t4_mem0", 32'(tb_mem[0]), 32'h1234);
    chk("t4_mem1", 32'(tb_mem[1]), 32'hABCD);
    chk("t4_mem2", 32'(tb_mem[2]), 32'h0007);
    chk("t4_wc", 32'(word_count), 3);
    chk("t4_q_empty", 32'(exp_q.size()), 0);

    // 5: reset after the first word is written
    @(negedge clk);
    do_start();
    push_wr(11'd0, 16'h1111);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h11); send_byte(8'h11);
    chk("t5_first_write", 32'(mem_en_write), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_ready", 32'(byte_ready), 0);
    chk("t5_en", 32'(mem_en_write), 0);
    chk("t5_hold", 32'(cpu_hold), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_err", 32'(err), 0);
    chk("t5_addr", 32'(mem_addr), 0);
    chk("t5_data", 32'(mem_data), 0);
    chk("t5_wc", 32'(word_count), 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    d0 = done_cnt;
    do_start();
    push_wr(11'd0, 16'hCAFE);
    push_wr(11'd1, 16'hBEEF);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'hCA); send_byte(8'hFE);
    send_byte(8'hBE); send_byte(8'hEF);
    wait_done(d0 + 1);
    chk("t5_wc_after", 32'(word_count), 2);
    chk("t5_mem1", 32'(tb_mem[1]), 32'hBEEF);

    // 6: maximum length, data = address, stray start mid-load
    @(negedge clk);
    #1;
    w0 = wr_cnt; d0 = done_cnt;
    do_start();
    send_byte(8'h08); send_byte(8'h00);
    for (int i = 0; i < 2048; i++) begin
      w = 16'(i);
      push_wr(w[10:0], w);
      if (i == 100) do_start();
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    wait_done(d0 + 1);
    chk("t6_wc", 32'(word_count), 2048);
    chk("t6_last_addr", 32'(last_addr), 32'h7FF);
    chk("t6_last_data", 32'(last_data), 32'h07FF);
    chk("t6_mem_top", 32'(tb_mem[2047]), 32'h07FF);
    chk("t6_mem100", 32'(tb_mem[100]), 32'h0064);
    chk("t6_writes", 32'(wr_cnt - w0), 2048);
    chk("t6_q_empty", 32'(exp_q.size()), 0);
    chk("t6_err", 32'(err), 0);
    @(negedge clk);
    chk("t6_hold_after", 32'(cpu_hold), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
